plb_lookup_stage: RTL and testbench

//  Second MPT-walk pipeline stage: sits directly after the fetch stage. It accepts one transaction
//  per handshake, looks its supervisor page number (SPN) up in a small fully-associative

---
 rtl/plb_lookup_stage.sv | 129 ++++++++++++
 tb/tb_plb_lookup_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plb_lookup_stage.sv
// MPT-walk lookup stage: registers each fetched transaction toward the walker together with
// the hit/permission result of a fully-associative PLB lookup on its SPN.
module plb_lookup_stage #(
  parameter int unsigned PIPELINE_SLAVE_DATA_WIDTH  = 128,
  parameter int unsigned PIPELINE_MASTER_DATA_WIDTH = 128,
  parameter int unsigned PLB_ENTRIES                = 8,
  parameter int unsigned SPN_LSB                    = 12,
  parameter int unsigned SPN_WIDTH                  = 40,
  parameter int unsigned PERM_WIDTH                 = 3
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  plb_slave_valid,
  output logic                                  plb_slave_ready,
  input  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0]  plb_slave_data,
  input  logic                                  plb_fault_i,
  output logic                                  plb_master_valid,
  input  logic                                  plb_master_ready,
  output logic [PIPELINE_MASTER_DATA_WIDTH-1:0] plb_master_data,
  output logic                                  plb_hit_o,
  output logic [PERM_WIDTH-1:0]                 plb_perm_o,
  output logic                                  plb_fault_o,
  input  logic                                  plb_ctrl_flush,
  input  logic                                  refill_valid_i,
  input  logic [SPN_WIDTH-1:0]                  refill_spn_i,
  input  logic [PERM_WIDTH-1:0]                 refill_perm_i
);

  localparam int unsigned PTR_W = (PLB_ENTRIES > 1) ? $clog2(PLB_ENTRIES) : 1;

  logic [PLB_ENTRIES-1:0]                r_ent_vld;
  logic [SPN_WIDTH-1:0]                  r_ent_tag  [PLB_ENTRIES];
  logic [PERM_WIDTH-1:0]                 r_ent_perm [PLB_ENTRIES];
  logic [PTR_W-1:0]                      r_ptr;

  logic                                  r_master_valid;
  logic [PIPELINE_MASTER_DATA_WIDTH-1:0] r_master_data;
  logic                                  r_hit;
  logic [PERM_WIDTH-1:0]                 r_perm;
  logic                                  r_fault;

  logic                                  w_accept;
  logic [SPN_WIDTH-1:0]                  w_spn;
  logic                                  w_hit;
  logic [PERM_WIDTH-1:0]                 w_perm;
  logic [PLB_ENTRIES-1:0]                w_refill_match;
  logic                                  w_refill_any;

  // No accept during a flush cycle; otherwise the output register frees itself in the same cycle
  assign plb_slave_ready = (!r_master_valid || plb_master_ready) && !plb_ctrl_flush;
  assign w_accept        = plb_slave_valid && plb_slave_ready;
  assign w_spn           = plb_slave_data[SPN_LSB +: SPN_WIDTH];

  // Parallel tag compare; tags are unique so OR-ing permissions yields the single match
  always_comb begin
    w_hit  = 1'b0;
    w_perm = '0;
    for (int i = 0; i < PLB_ENTRIES; i++) begin
      if (r_ent_vld[i] && (r_ent_tag[i] == w_spn)) begin
        w_hit  = 1'b1;
        w_perm = w_perm | r_ent_perm[i];
      end
    end
  end

  always_comb begin
    w_refill_match = '0;
    for (int i = 0; i < PLB_ENTRIES; i++) begin
      w_refill_match[i] = r_ent_vld[i] && (r_ent_tag[i] == refill_spn_i);
    end
  end

  assign w_refill_any = |w_refill_match;

  // PLB storage: in-place permission update on tag match, else round-robin allocation
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ent_vld <= '0;
      r_ptr     <= '0;
      for (int i = 0; i < PLB_ENTRIES; i++) begin
        r_ent_tag[i]  <= '0;
        r_ent_perm[i] <= '0;
      end
    end else if (plb_ctrl_flush) begin
      r_ent_vld <= '0;
    end else if (refill_valid_i) begin
      if (w_refill_any) begin
        for (int i = 0; i < PLB_ENTRIES; i++) begin
          if (w_refill_match[i]) begin
            r_ent_perm[i] <= refill_perm_i;
          end
        end
      end else begin
        r_ent_vld[r_ptr]  <= 1'b1;
        r_ent_tag[r_ptr]  <= refill_spn_i;
        r_ent_perm[r_ptr] <= refill_perm_i;
        r_ptr             <= r_ptr + PTR_W'(1);
      end
    end
  end

  // Output register toward the walk stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_master_valid <= 1'b0;
      r_master_data  <= '0;
      r_hit          <= 1'b0;
      r_perm         <= '0;
      r_fault        <= 1'b0;
    end else if (plb_ctrl_flush) begin
      r_master_valid <= 1'b0;
    end else if (w_accept) begin
      r_master_valid <= 1'b1;
      r_master_data  <= PIPELINE_MASTER_DATA_WIDTH'(plb_slave_data);
      r_hit          <= w_hit && !plb_fault_i;
      r_perm         <= plb_fault_i ? '0 : w_perm;
      r_fault        <= plb_fault_i;
    end else if (plb_master_ready) begin
      r_master_valid <= 1'b0;
    end
  end

  assign plb_master_valid = r_master_valid;
  assign plb_master_data  = r_master_data;
  assign plb_hit_o        = r_hit;
  assign plb_perm_o       = r_perm;
  assign plb_fault_o      = r_fault;

endmodule

// File: tb/tb_plb_lookup_stage.sv
// Scoreboard bench for plb_lookup_stage: a reference PLB model predicts each accepted
// transaction's sideband; the output monitor pops and compares on every handshake.
module tb_plb_lookup_stage;

  localparam int unsigned DW = 128;
  localparam int unsigned N  = 8;
  localparam int unsigned SL = 12;
  localparam int unsigned SW = 40;
  localparam int unsigned PW = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          hit;
    logic [PW-1:0] perm;
    logic          fault;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          plb_slave_valid;
  logic          plb_slave_ready;
  logic [DW-1:0] plb_slave_data;
  logic          plb_fault_i;
  logic          plb_master_valid;
  logic          plb_master_ready;
  logic [DW-1:0] plb_master_data;
  logic          plb_hit_o;
  logic [PW-1:0] plb_perm_o;
  logic          plb_fault_o;
  logic          plb_ctrl_flush;
  logic          refill_valid_i;
  logic [SW-1:0] refill_spn_i;
  logic [PW-1:0] refill_perm_i;

  exp_t          sb_q[$];
  int            n_cmp = 0;
  int            n_err = 0;

  logic          m_vld  [N];
  logic [SW-1:0] m_tag  [N];
  logic [PW-1:0] m_perm [N];
  int            m_ptr;

  plb_lookup_stage dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .plb_slave_valid  (plb_slave_valid),
    .plb_slave_ready  (plb_slave_ready),
    .plb_slave_data   (plb_slave_data),
    .plb_fault_i      (plb_fault_i),
    .plb_master_valid (plb_master_valid),
    .plb_master_ready (plb_master_ready),
    .plb_master_data  (plb_master_data),
    .plb_hit_o        (plb_hit_o),
    .plb_perm_o       (plb_perm_o),
    .plb_fault_o      (plb_fault_o),
    .plb_ctrl_flush   (plb_ctrl_flush),
    .refill_valid_i   (refill_valid_i),
    .refill_spn_i     (refill_spn_i),
    .refill_perm_i    (refill_perm_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model_lookup(input logic [DW-1:0] d, input logic f);
    exp_t e;
    e.data  = d;
    e.fault = f;
    e.hit   = 1'b0;
    e.perm  = '0;
    if (!f) begin
      for (int i = 0; i < N; i++) begin
        if (m_vld[i] && (m_tag[i] == d[SL +: SW])) begin
          e.hit  = 1'b1;
          e.perm = m_perm[i];
        end
      end
    end
    return e;
  endfunction

  function automatic void model_refill(input logic [SW-1:0] s, input logic [PW-1:0] p);
    bit found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m_vld[i] && (m_tag[i] == s)) begin
        m_perm[i] = p;
        found     = 1'b1;
      end
    end
    if (!found) begin
      m_vld[m_ptr]  = 1'b1;
      m_tag[m_ptr]  = s;
      m_perm[m_ptr] = p;
      m_ptr         = (m_ptr + 1) % N;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_vld[i]  = 1'b0;
      m_tag[i]  = '0;
      m_perm[i] = '0;
    end
    m_ptr = 0;
    sb_q.delete();
  endfunction

  // One clock: predict on accept before the edge, then apply flush/refill to the model
  task automatic tick(output bit acc);
    @(negedge clk_i);
    #1;
    acc = plb_slave_valid && plb_slave_ready;
    if (acc) sb_q.push_back(model_lookup(plb_slave_data, plb_fault_i));
    @(posedge clk_i);
    if (plb_ctrl_flush) begin
      for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
      sb_q.delete();
    end else if (refill_valid_i) begin
      model_refill(refill_spn_i, refill_perm_i);
    end
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) tick(acc);
  endtask

  task automatic set_txn(input logic [SW-1:0] spn, input logic f);
    plb_slave_valid              = 1'b1;
    plb_slave_data               = {$urandom, $urandom, $urandom, $urandom};
    plb_slave_data[SL +: SW]     = spn;
    plb_fault_i                  = f;
  endtask

  task automatic send(input logic [SW-1:0] spn, input logic f);
    bit acc;
    set_txn(spn, f);
    tick(acc);
    check("accept", DW'(acc), DW'(1));
    plb_slave_valid = 1'b0;
    plb_fault_i     = 1'b0;
  endtask

  task automatic refill(input logic [SW-1:0] spn, input logic [PW-1:0] perm);
    bit acc;
    refill_valid_i = 1'b1;
    refill_spn_i   = spn;
    refill_perm_i  = perm;
    tick(acc);
    refill_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni           = 1'b0;
    plb_slave_valid  = 1'b0;
    plb_fault_i      = 1'b0;
    plb_ctrl_flush   = 1'b0;
    refill_valid_i   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  // Output monitor: a handshake completes at the next rising edge
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni && plb_master_valid && plb_master_ready) begin
      if (sb_q.size() == 0) begin
        check("spurious_out", DW'(1), DW'(0));
      end else begin
        e = sb_q.pop_front();
        check("out_data",  plb_master_data,   e.data);
        check("out_hit",   DW'(plb_hit_o),    DW'(e.hit));
        check("out_perm",  DW'(plb_perm_o),   DW'(e.perm));
        check("out_fault", DW'(plb_fault_o),  DW'(e.fault));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    exp_t hold;
    plb_slave_data   = '0;
    plb_master_ready = 1'b1;
    refill_spn_i     = '0;
    refill_perm_i    = '0;
    rst_ni           = 1'b0;
    plb_slave_valid  = 1'b0;
    plb_fault_i      = 1'b0;
    plb_ctrl_flush   = 1'b0;
    refill_valid_i   = 1'b0;
    model_reset();
    #3;
    check("rst_valid", DW'(plb_master_valid), DW'(0));
    check("rst_data",  plb_master_data,       DW'(0));
    check("rst_hit",   DW'(plb_hit_o),        DW'(0));
    check("rst_perm",  DW'(plb_perm_o),       DW'(0));
    check("rst_fault", DW'(plb_fault_o),      DW'(0));
    check("rst_ready", DW'(plb_slave_ready),  DW'(1));
    do_reset();

    // Cold miss, one-cycle latency
    send(40'h5, 1'b0);
    check("lat_valid", DW'(plb_master_valid), DW'(1));
    idle(2);

    // Refill then hit; same-cycle lookup of a tag being refilled sees the old contents
    refill(40'h5, 3'b011);
    send(40'h5, 1'b0);
    refill_valid_i = 1'b1;
    refill_spn_i   = 40'h7;
    refill_perm_i  = 3'b110;
    send(40'h7, 1'b0);
    refill_valid_i = 1'b0;
    send(40'h7, 1'b0);
    refill(40'h5, 3'b101);
    send(40'h5, 1'b0);
    send(40'h5, 1'b1);
    idle(2);

    // Capacity and round-robin wrap
    do_reset();
    for (int s = 'h10; s <= 'h18; s++) refill(SW'(s), PW'(s));
    for (int s = 'h10; s <= 'h18; s++) send(SW'(s), 1'b0);
    refill(40'h20, 3'b111);
    send(40'h11, 1'b0);
    send(40'h12, 1'b0);
    send(40'h20, 1'b0);
    idle(2);

    // Backpressure: output must hold and input must stall
    plb_master_ready = 1'b0;
    send(40'h12, 1'b0);
    set_txn(40'h13, 1'b0);
    for (int k = 0; k < 3; k++) begin
      hold = sb_q[0];
      check("stall_ready", DW'(plb_slave_ready),  DW'(0));
      check("stall_valid", DW'(plb_master_valid), DW'(1));
      check("stall_data",  plb_master_data,       hold.data);
      check("stall_perm",  DW'(plb_perm_o),       DW'(hold.perm));
      tick(acc);
    end
    plb_master_ready = 1'b1;
    #1;
    check("release_ready", DW'(plb_slave_ready), DW'(1));
    tick(acc);
    check("release_acc", DW'(acc), DW'(1));
    plb_slave_valid = 1'b0;
    idle(2);

    // Flush beats a simultaneous refill and drops a stalled output
    refill(40'h5, 3'b001);
    plb_master_ready = 1'b0;
    send(40'h5, 1'b0);
    set_txn(40'h6, 1'b0);
    plb_ctrl_flush = 1'b1;
    refill_valid_i = 1'b1;
    refill_spn_i   = 40'h6;
    refill_perm_i  = 3'b010;
    #1;
    check("flush_ready", DW'(plb_slave_ready), DW'(0));
    tick(acc);
    plb_ctrl_flush   = 1'b0;
    refill_valid_i   = 1'b0;
    plb_slave_valid  = 1'b0;
    check("flush_valid", DW'(plb_master_valid), DW'(0));
    plb_master_ready = 1'b1;
    send(40'h5, 1'b0);
    send(40'h6, 1'b0);
    idle(2);

    // Asynchronous reset while an output is pending
    plb_master_ready = 1'b0;
    send(40'h12, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_valid", DW'(plb_master_valid), DW'(0));
    check("arst_data",  plb_master_data,       DW'(0));
    plb_master_ready = 1'b1;
    do_reset();
    send(40'h12, 1'b0);
    idle(3);

    check("sb_drained", DW'(sb_q.size()), DW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
